// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, branch redirect and the decode channel.
// master = fetch unit, slave = memory/branch/decode side.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target,
           inst_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch: owns the fetch PC, issues credit-limited word reads,
// buffers in-order responses with their PCs and hands {inst, pc} to decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  instruction_fetch_unit_if.master        bus,
  output logic                            dbg_flushing
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state;
  logic          running;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] drop_cnt;
  logic [PW-1:0] fifo_rd, fifo_wr, tag_rd, tag_wr;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   tag_pc    [FIFO_DEPTH];

  logic          pop, accept, push, dropping, req_valid;
  logic [CW:0]   load;

  // Handshakes: a transfer happens on a cycle where valid && ready; valid never waits on
  // ready, and payload holds while valid && !ready (a redirect may withdraw a request).
  // The buffer slot freed by this cycle's decode pop counts as credit, allowing full rate.
  assign pop       = (fifo_count != '0) && bus.inst_ready;
  assign load      = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign req_valid = running && (state == FETCH) && !bus.redirect_valid &&
                     (load < (CW+1)'(FIFO_DEPTH));
  assign accept    = req_valid && bus.imem_req_ready;
  assign dropping  = bus.imem_rsp_valid && (drop_cnt != '0);
  assign push      = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = (fifo_count != '0);
  assign bus.inst_data      = fifo_data[fifo_rd];
  assign bus.inst_pc        = fifo_pc[fifo_rd];
  assign dbg_flushing       = (state == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      running     <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      fifo_count  <= '0;
      drop_cnt    <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
        tag_pc[i]    <= '0;
      end
    end else begin
      running     <= 1'b1;
      outstanding <= outstanding + CW'(accept) - CW'(bus.imem_rsp_valid);
      if (accept) begin
        tag_pc[tag_wr] <= fetch_pc;
        tag_wr         <= tag_wr + PW'(1);
      end
      if (bus.imem_rsp_valid) tag_rd <= tag_rd + PW'(1);

      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle is stale and must be discarded.
        fetch_pc   <= bus.redirect_target & 32'hFFFF_FFFC;
        fifo_count <= '0;
        fifo_rd    <= '0;
        fifo_wr    <= '0;
        drop_cnt   <= outstanding - CW'(bus.imem_rsp_valid);
        state      <= (outstanding != CW'(bus.imem_rsp_valid)) ? FLUSH : FETCH;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          fifo_data[fifo_wr] <= bus.imem_rsp_data;
          fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
          fifo_wr            <= fifo_wr + PW'(1);
        end
        if (pop) fifo_rd <= fifo_rd + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (dropping) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: fixed-latency memory, queue-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic dbg_flushing;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_flushing(dbg_flushing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ib_t;

  mreq_t       mem_q[$];
  fl_t         m_fl[$];
  ib_t         m_buf[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_started = 1'b0;

  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];
  int          dlv_cyc_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] at32(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int at_int(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory: fixed latency, in-order, one response per accepted request.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_q.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  end

  // Reference model + per-cycle compare, sampled mid-cycle after inputs settle.
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      m_fl.delete();
      m_buf.delete();
      m_pc      = RESET_PC;
      m_started = 1'b0;
    end else begin
      bit   flushing;
      bit   exp_valid;
      bit   exp_pop;
      int   load;
      fl_t  f;
      flushing = 1'b0;
      foreach (m_fl[i]) if (m_fl[i].stale) flushing = 1'b1;
      exp_pop   = (m_buf.size() > 0) && bus.inst_ready;
      load      = m_fl.size() + m_buf.size() - (exp_pop ? 1 : 0);
      exp_valid = m_started && !flushing && !bus.redirect_valid && (load < DEPTH);

      chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_valid));
      chk("req_addr", bus.imem_req_addr, m_pc);
      chk("inst_valid", 32'(bus.inst_valid), 32'(m_buf.size() > 0));
      chk("flushing", 32'(dbg_flushing), 32'(flushing));
      if (m_buf.size() > 0) begin
        chk("inst_data", bus.inst_data, m_buf[0].data);
        chk("inst_pc", bus.inst_pc, m_buf[0].pc);
      end

      if (bus.imem_req_valid && bus.imem_req_ready) begin
        acc_q.push_back(bus.imem_req_addr);
        acc_cyc_q.push_back(cyc);
        mem_q.push_back('{bus.imem_req_addr, cyc + lat});
      end
      if (bus.inst_valid && bus.inst_ready) begin
        exp_q.push_back(bus.inst_pc);
        dlv_cyc_q.push_back(cyc);
      end

      if (exp_pop) void'(m_buf.pop_front());
      if (bus.imem_rsp_valid) begin
        if (m_fl.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          f = m_fl.pop_front();
          if (!f.stale && !bus.redirect_valid) m_buf.push_back('{mem_word(f.pc), f.pc});
        end
      end
      if (bus.redirect_valid) begin
        m_buf.delete();
        foreach (m_fl[i]) m_fl[i].stale = 1'b1;
        m_pc = bus.redirect_target & 32'hFFFF_FFFC;
      end else if (exp_valid && bus.imem_req_ready) begin
        m_fl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
      m_started = 1'b1;
    end
    cyc++;
  end

  task automatic clear_logs();
    acc_q.delete();
    acc_cyc_q.delete();
    exp_q.delete();
    dlv_cyc_q.delete();
  endtask

  task automatic do_reset(input int latency, input logic ready_in);
    @(negedge clk);
    rst_n               = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.imem_req_ready  = 1'b1;
    bus.inst_ready      = ready_in;
    lat                 = latency;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input string name, input int n);
    int k = 0;
    while (acc_q.size() < n && k < 100) begin @(negedge clk); k++; end
    chk(name, 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_dlv(input string name, input int n);
    int k = 0;
    while (exp_q.size() < n && k < 100) begin @(negedge clk); k++; end
    chk(name, 32'(exp_q.size() >= n), 32'd1);
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.inst_ready      = 1'b0;
    #2;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);

    // Streaming with 1-cycle memory.
    do_reset(1, 1'b1);
    repeat (8) @(negedge clk);
    chk("t1_acc0", at32(acc_q, 0), 32'h0);
    chk("t1_acc1", at32(acc_q, 1), 32'h4);
    chk("t1_acc2", at32(acc_q, 2), 32'h8);
    chk("t1_consecutive", 32'(at_int(acc_cyc_q, 2) - at_int(acc_cyc_q, 0)), 32'd2);
    chk("t1_dlv0", at32(exp_q, 0), 32'h0);
    chk("t1_dlv1", at32(exp_q, 1), 32'h4);
    chk("t1_dlv2", at32(exp_q, 2), 32'h8);
    chk("t1_latency", 32'(at_int(dlv_cyc_q, 0) - at_int(acc_cyc_q, 0)), 32'd2);

    // Decode stalled: credit caps the requests at the buffer depth.
    do_reset(1, 1'b0);
    repeat (6) @(negedge clk);
    chk("t2_acc_count", 32'(acc_q.size()), 32'd2);
    #1 chk("t2_req_low", 32'(bus.imem_req_valid), 32'd0);
    bus.inst_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t2_dlv0", at32(exp_q, 0), 32'h0);
    chk("t2_dlv1", at32(exp_q, 1), 32'h4);
    chk("t2_acc2", at32(acc_q, 2), 32'h8);

    // 3-cycle memory, redirect with two requests in flight.
    do_reset(3, 1'b1);
    wait_acc("t3_wait_acc", 2);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1 chk("t3_flush_state", 32'(dbg_flushing), 32'd1);
    wait_dlv("t3_wait_dlv", 1);
    chk("t3_acc_after", at32(acc_q, 2), 32'h100);
    chk("t3_first_dlv", at32(exp_q, 0), 32'h100);

    // Redirect coinciding with a response and a decode handshake.
    do_reset(1, 1'b1);
    wait_dlv("t4_wait_dlv", 3);
    #1;
    chk("t4_setup", 32'(bus.imem_rsp_valid && bus.inst_valid && bus.inst_ready), 32'd1);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_dlv3", at32(exp_q, 3), 32'hC);
    chk("t4_dlv4", at32(exp_q, 4), 32'h200);
    chk("t4_dlv5", at32(exp_q, 5), 32'h204);

    // PC wrap at the top of the address space.
    do_reset(1, 1'b1);
    @(negedge clk);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFA;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_acc0", at32(acc_q, 0), 32'hFFFF_FFF8);
    chk("t5_acc1", at32(acc_q, 1), 32'hFFFF_FFFC);
    chk("t5_acc2", at32(acc_q, 2), 32'h0);
    chk("t5_dlv1", at32(exp_q, 1), 32'hFFFF_FFFC);
    chk("t5_dlv2", at32(exp_q, 2), 32'h0);
    chk("t5_dlv3", at32(exp_q, 3), 32'h4);

    // Asynchronous reset while flushing.
    do_reset(4, 1'b1);
    wait_acc("t6_wait_acc", 2);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0300;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1 chk("t6_flushing", 32'(dbg_flushing), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_req_addr", bus.imem_req_addr, RESET_PC);
    chk("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("t6_inst_data", bus.inst_data, 32'd0);
    chk("t6_inst_pc", bus.inst_pc, 32'd0);
    chk("t6_state", 32'(dbg_flushing), 32'd0);
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    wait_dlv("t6_wait_dlv", 1);
    chk("t6_acc0", at32(acc_q, 0), RESET_PC);
    chk("t6_dlv0", at32(exp_q, 0), RESET_PC);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
